// File: rtl/cache_ctrl_pkg.sv
// rtl/cache_ctrl_pkg.sv - shared types and default widths for the cache controller
package cache_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH  = 32;
    localparam int DEF_WORD_SIZE   = 32;
    localparam int DEF_MEM_TIMEOUT = 64;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        ALLOCATE,
        RESP
    } state_e;

endpackage

// File: rtl/cache_ctrl_watchdog.sv
// rtl/cache_ctrl_watchdog.sv - memory-phase watchdog: clears on load, counts while enabled, flags expiry
module cache_ctrl_watchdog #(
    parameter int MEM_TIMEOUT = 64,
    parameter int TO_CNT_W    = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    logic [TO_CNT_W-1:0] cnt_q, cnt_d;

    // Counter holds the number of cycles already spent in the current memory phase
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + TO_CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry is raised during the MEM_TIMEOUT-th cycle of the phase
    assign expire = en && (cnt_q == TO_CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/cache_ctrl_fsm.sv
// rtl/cache_ctrl_fsm.sv - cache sequencing FSM; optional statistics under CACHE_CTRL_STATS_EN
module cache_ctrl_fsm
    import cache_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int WORD_SIZE   = DEF_WORD_SIZE,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int TO_CNT_W    = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_valid,
    output logic                  cpu_ready,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0]  cpu_wdata,
    output logic                  cpu_resp_valid,
    output logic [WORD_SIZE-1:0]  cpu_rdata,
    output logic                  cpu_err,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [WORD_SIZE-1:0]  cache_wdata,
    output logic                  req_type,
    output logic                  read_en_cache,
    output logic                  write_en_cache,
    output logic                  read_en_mem,
    output logic                  write_en_mem,
    output logic                  refill,
    input  logic                  hit,
    input  logic                  dirty_bit,
    input  logic [WORD_SIZE-1:0]  cache_rdata,
    input  logic                  mem_ack,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt,
    output logic [31:0]           wb_cnt
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0]  wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  refill_pass_q, refill_pass_d;
    logic                  err_q, err_d;
    logic                  rd_hit_q, rd_hit_d;
    logic                  wd_load, wd_en, wd_expire;

    // Watchdog is cleared on entry to either memory phase, including WRITEBACK -> ALLOCATE
    assign wd_en   = (state_q == WRITEBACK) || (state_q == ALLOCATE);
    assign wd_load = ((state_d == WRITEBACK) && (state_q != WRITEBACK)) ||
                     ((state_d == ALLOCATE)  && (state_q != ALLOCATE));

    cache_ctrl_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_CNT_W    (TO_CNT_W)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (wd_load),
        .en     (wd_en),
        .expire (wd_expire)
    );

    // Next-state, request latching and strobe generation
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        we_d           = we_q;
        refill_pass_d  = refill_pass_q;
        err_d          = err_q;
        rd_hit_d       = rd_hit_q;
        cpu_ready      = 1'b0;
        cpu_resp_valid = 1'b0;
        cpu_rdata      = '0;
        cpu_err        = 1'b0;
        read_en_cache  = 1'b0;
        write_en_cache = 1'b0;
        read_en_mem    = 1'b0;
        write_en_mem   = 1'b0;
        refill         = 1'b0;
        case (state_q)
            IDLE: begin
                cpu_ready = 1'b1;
                if (cpu_valid) begin
                    addr_d        = cpu_addr;
                    wdata_d       = cpu_wdata;
                    we_d          = cpu_we;
                    refill_pass_d = 1'b0;
                    err_d         = 1'b0;
                    rd_hit_d      = 1'b0;
                    state_d       = COMPARE;
                end
            end
            COMPARE: begin
                refill = refill_pass_q;
                if (hit) begin
                    read_en_cache  = !we_q;
                    write_en_cache = we_q;
                    rd_hit_d       = !we_q;
                    state_d        = RESP;
                end else if (refill_pass_q) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (dirty_bit) begin
                    state_d = WRITEBACK;
                end else begin
                    state_d = ALLOCATE;
                end
            end
            WRITEBACK: begin
                read_en_cache = 1'b1;
                write_en_mem  = 1'b1;
                if (mem_ack) begin
                    state_d = ALLOCATE;
                end else if (wd_expire) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            ALLOCATE: begin
                read_en_mem = 1'b1;
                if (mem_ack) begin
                    write_en_cache = 1'b1;
                    refill_pass_d  = 1'b1;
                    state_d        = COMPARE;
                end else if (wd_expire) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                cpu_resp_valid = 1'b1;
                cpu_err        = err_q;
                cpu_rdata      = rd_hit_q ? cache_rdata : '0;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched request registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            we_q          <= 1'b0;
            refill_pass_q <= 1'b0;
            err_q         <= 1'b0;
            rd_hit_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            we_q          <= we_d;
            refill_pass_q <= refill_pass_d;
            err_q         <= err_d;
            rd_hit_q      <= rd_hit_d;
        end
    end

    assign cache_addr  = addr_q;
    assign cache_wdata = wdata_q;
    assign req_type    = we_q;

`ifdef CACHE_CTRL_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic [31:0] wb_cnt_q, wb_cnt_d;

    // Saturating event counters; only first-pass lookups count as hits or misses
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        wb_cnt_d   = wb_cnt_q;
        if ((state_q == COMPARE) && !refill_pass_q) begin
            if (hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_d = hit_cnt_q + 32'd1;
            end
            if (!hit && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
        if ((state_q == WRITEBACK) && mem_ack && (wb_cnt_q != 32'hFFFF_FFFF)) begin
            wb_cnt_d = wb_cnt_q + 32'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            wb_cnt_q   <= wb_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
    assign wb_cnt   = wb_cnt_q;
`else
    assign hit_cnt  = 32'd0;
    assign miss_cnt = 32'd0;
    assign wb_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// tb/tb_cache_ctrl_fsm.sv - randomized and directed self-checking bench for cache_ctrl_fsm
module tb_cache_ctrl_fsm;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_valid, cpu_ready, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_resp_valid, cpu_err;
    logic [31:0] cache_addr, cache_wdata, cache_rdata;
    logic        req_type, read_en_cache, write_en_cache, read_en_mem, write_en_mem, refill;
    logic        hit, dirty_bit, mem_ack;
    logic [31:0] hit_cnt, miss_cnt, wb_cnt;

    always #5 clk = ~clk;

    cache_ctrl_fsm #(
        .ADDR_WIDTH  (32),
        .WORD_SIZE   (32),
        .MEM_TIMEOUT (T)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_valid      (cpu_valid),
        .cpu_ready      (cpu_ready),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_resp_valid (cpu_resp_valid),
        .cpu_rdata      (cpu_rdata),
        .cpu_err        (cpu_err),
        .cache_addr     (cache_addr),
        .cache_wdata    (cache_wdata),
        .req_type       (req_type),
        .read_en_cache  (read_en_cache),
        .write_en_cache (write_en_cache),
        .read_en_mem    (read_en_mem),
        .write_en_mem   (write_en_mem),
        .refill         (refill),
        .hit            (hit),
        .dirty_bit      (dirty_bit),
        .cache_rdata    (cache_rdata),
        .mem_ack        (mem_ack),
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt),
        .wb_cnt         (wb_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Current transaction scenario and its derived timeline
    logic        s_we, s_h1, s_d1, s_h2;
    logic [31:0] s_addr, s_wdata, s_rdw;
    int          s_nwb, s_nal;
    int          wb_len, al_len, a0, L;
    logic        wb_to, al_to, cmp2, s_err;

    int          resp_cnt, resp_cyc;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [31:0] m_hit = 0, m_miss = 0, m_wb = 0;

    task automatic expect32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic bit in_win(input int n);
        return (n >= 1) && (n <= T);
    endfunction

    // Build the expected phase timeline: compare, writeback, allocate, re-compare, response
    task automatic plan(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic h1, input logic d1, input logic h2,
                        input int nwb, input int nal, input logic [31:0] rdw);
        s_we = we; s_addr = addr; s_wdata = wdata; s_h1 = h1; s_d1 = d1; s_h2 = h2;
        s_nwb = nwb; s_nal = nal; s_rdw = rdw;
        wb_to  = !h1 && d1 && !in_win(nwb);
        wb_len = (!h1 && d1) ? (in_win(nwb) ? nwb : T) : 0;
        al_to  = !h1 && !wb_to && !in_win(nal);
        al_len = (!h1 && !wb_to) ? (in_win(nal) ? nal : T) : 0;
        cmp2   = !h1 && !wb_to && !al_to;
        a0     = 2 + wb_len;
        L      = a0 + al_len + (cmp2 ? 1 : 0);
        s_err  = wb_to || al_to || (cmp2 && !h2);
    endtask

    // Expected {ready, rd_cache, wr_cache, rd_mem, wr_mem, refill, resp_valid, err} in cycle k
    function automatic logic [7:0] exp_vec(input int k);
        logic [7:0] v;
        v = 8'd0;
        if (k > L) begin
            v[7] = 1'b1;
        end else if (k == L) begin
            v[1] = 1'b1;
            v[0] = s_err;
        end else if (k == 1) begin
            v[6] = s_h1 && !s_we;
            v[5] = s_h1 && s_we;
        end else if (k < a0) begin
            v[6] = 1'b1;
            v[3] = 1'b1;
        end else if (k < a0 + al_len) begin
            v[4] = 1'b1;
            v[5] = (k == a0 + al_len - 1) && !al_to;
        end else begin
            v[2] = 1'b1;
            v[6] = s_h2 && !s_we;
            v[5] = s_h2 && s_we;
        end
        return v;
    endfunction

    task automatic drive_cycle(input int k);
        hit       = (cmp2 && (k == a0 + al_len)) ? s_h2 : s_h1;
        dirty_bit = s_d1;
        mem_ack   = ((k >= 2) && (k < a0) && (k == 1 + s_nwb) && !wb_to) ||
                    ((k >= a0) && (k < a0 + al_len) && (k == a0 - 1 + s_nal) && !al_to);
        cache_rdata = ((k == L) && !s_err && !s_we) ? s_rdw : ($urandom() | 32'h1);
        cpu_valid = (k <= L) ? 1'($urandom_range(0, 1)) : 1'b0;
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = $urandom();
        cpu_wdata = $urandom();
    endtask

    task automatic check_cycle(input int k);
        logic [7:0]  got;
        logic [31:0] exp_rd;
        got = {cpu_ready, read_en_cache, write_en_cache, read_en_mem, write_en_mem,
               refill, cpu_resp_valid, cpu_err};
        expect32($sformatf("strobes_c%0d", k), {24'd0, got}, {24'd0, exp_vec(k)});
        exp_rd = ((k == L) && !s_err && !s_we) ? s_rdw : 32'd0;
        expect32($sformatf("rdata_c%0d", k), cpu_rdata, exp_rd);
        expect32($sformatf("latch_addr_c%0d", k), cache_addr, s_addr);
        expect32($sformatf("latch_wd_we_c%0d", k), cache_wdata ^ {31'd0, req_type},
                 s_wdata ^ {31'd0, s_we});
        if (cpu_resp_valid) begin
            resp_cnt++;
            resp_cyc  = k;
            resp_data = cpu_rdata;
            resp_err  = cpu_err;
        end
    endtask

    task automatic check_stats(input string tag);
`ifdef CACHE_CTRL_STATS_EN
        expect32({tag, "_hit_cnt"}, hit_cnt, m_hit);
        expect32({tag, "_miss_cnt"}, miss_cnt, m_miss);
        expect32({tag, "_wb_cnt"}, wb_cnt, m_wb);
`else
        expect32({tag, "_stats_tied"}, hit_cnt | miss_cnt | wb_cnt, 32'd0);
`endif
    endtask

    // Called one time unit after a rising edge with the controller idle
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic h1, input logic d1, input logic h2,
                           input int nwb, input int nal, input logic [31:0] rdw);
        plan(we, addr, wdata, h1, d1, h2, nwb, nal, rdw);
        resp_cnt  = 0;
        resp_cyc  = -1;
        resp_data = 32'd0;
        resp_err  = 1'b0;
        cpu_valid = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        hit       = 1'b0;
        mem_ack   = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= L + 1; k++) begin
            #1;
            drive_cycle(k);
            @(negedge clk);
            check_cycle(k);
            @(posedge clk);
        end
        #1;
        cpu_valid = 1'b0;
        mem_ack   = 1'b0;
        m_hit  = m_hit + {31'd0, h1};
        m_miss = m_miss + {31'd0, !h1};
        m_wb   = m_wb + {31'd0, (!h1 && d1 && !wb_to)};
        expect32("resp_count", 32'(resp_cnt), 32'd1);
        check_stats("txn");
    endtask

    initial begin
        rst_n = 1'b0; cpu_valid = 1'b0; cpu_we = 1'b0; cpu_addr = 0; cpu_wdata = 0;
        hit = 1'b0; dirty_bit = 1'b0; mem_ack = 1'b0; cache_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        expect32("reset_ready", {31'd0, cpu_ready}, 32'd1);
        expect32("reset_strobes", {25'd0, read_en_cache, write_en_cache, read_en_mem,
                 write_en_mem, refill, cpu_resp_valid, cpu_err}, 32'd0);
        expect32("reset_addr", cache_addr, 32'd0);
        expect32("reset_wdata_we", cache_wdata | {31'd0, req_type}, 32'd0);
        expect32("reset_rdata", cpu_rdata, 32'd0);
        check_stats("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Read hit
        run_txn(1'b0, 32'h0000_0040, 32'h0, 1'b1, 1'b0, 1'b1, 0, 0, 32'hDEAD_0010);
        expect32("rd_hit_lat", 32'(resp_cyc), 32'd2);
        expect32("rd_hit_data", resp_data, 32'hDEAD_0010);
        expect32("rd_hit_err", {31'd0, resp_err}, 32'd0);
        // Write hit
        run_txn(1'b1, 32'h0000_0080, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 0, 0, 32'h5555_AAAA);
        expect32("wr_hit_lat", 32'(resp_cyc), 32'd2);
        expect32("wr_hit_data", resp_data, 32'd0);
        // Clean miss, ack in third allocate cycle
        run_txn(1'b0, 32'h0000_0100, 32'h0, 1'b0, 1'b0, 1'b1, 0, 3, 32'hCAFE_0001);
        expect32("clean_lat", 32'(resp_cyc), 32'd6);
        expect32("clean_data", resp_data, 32'hCAFE_0001);
        // Dirty miss, writeback ack after 2, allocate ack after 1
        run_txn(1'b0, 32'h0000_0200, 32'h0, 1'b0, 1'b1, 1'b1, 2, 1, 32'hBEEF_0002);
        expect32("dirty_lat", 32'(resp_cyc), 32'd6);
        expect32("dirty_data", resp_data, 32'hBEEF_0002);
        // Allocate never acknowledged
        run_txn(1'b0, 32'h0000_0300, 32'h0, 1'b0, 1'b0, 1'b1, 0, 0, 32'h1111_1111);
        expect32("alloc_to_lat", 32'(resp_cyc), 32'd6);
        expect32("alloc_to_err", {31'd0, resp_err}, 32'd1);
        // Writeback never acknowledged
        run_txn(1'b1, 32'h0000_0340, 32'h7777_0000, 1'b0, 1'b1, 1'b1, 0, 1, 32'h0);
        expect32("wb_to_lat", 32'(resp_cyc), 32'd6);
        expect32("wb_to_err", {31'd0, resp_err}, 32'd1);
        // Re-lookup still misses
        run_txn(1'b0, 32'h0000_0400, 32'h0, 1'b0, 1'b0, 1'b0, 0, 1, 32'h2222_2222);
        expect32("refill_fail_lat", 32'(resp_cyc), 32'd4);
        expect32("refill_fail_err", {31'd0, resp_err}, 32'd1);
        // Ack arrives in the expiry cycle and wins
        run_txn(1'b0, 32'h0000_0440, 32'h0, 1'b0, 1'b0, 1'b1, 0, T, 32'h3333_3333);
        expect32("ack_at_expiry_lat", 32'(resp_cyc), 32'd7);
        expect32("ack_at_expiry_err", {31'd0, resp_err}, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            run_txn(1'($urandom_range(0, 1)), $urandom(), $urandom(),
                    ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) != 0), int'($urandom_range(0, T)),
                    int'($urandom_range(0, T)), $urandom());
        end

        // Reset while allocating
        plan(1'b0, 32'h0000_0500, 32'h0, 1'b0, 1'b0, 1'b1, 0, 0, 32'h0);
        cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0500; cpu_wdata = 32'h0;
        hit = 1'b0; dirty_bit = 1'b0; mem_ack = 1'b0;
        @(posedge clk);
        #1;
        cpu_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        expect32("abort_pre_rd_mem", {31'd0, read_en_mem}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        expect32("abort_strobes", {25'd0, read_en_cache, write_en_cache, read_en_mem,
                 write_en_mem, refill, cpu_resp_valid, cpu_err}, 32'd0);
        expect32("abort_addr", cache_addr, 32'd0);
        m_hit = 0; m_miss = 0; m_wb = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            expect32("abort_ready", {31'd0, cpu_ready}, 32'd1);
            expect32("abort_no_resp", {31'd0, cpu_resp_valid}, 32'd0);
        end
        check_stats("abort");
        @(posedge clk);
        #1;
        run_txn(1'b0, 32'h0000_0600, 32'h0, 1'b1, 1'b0, 1'b1, 0, 0, 32'h4444_0044);
        expect32("post_abort_data", resp_data, 32'h4444_0044);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
